// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: datapath-facing bus of the multicycle control FSM
interface control_multiciclo_if;
  logic [5:0] op;
  logic       imem_ready;
  logic       dmem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       enW_Bank;
  logic       enW_Mem;
  logic       enR_Mem;
  logic       selMuxMem_ALU;
  logic       selMuxAddr;
  logic       selMuxSign_Bank;
  logic [3:0] selControl;
  logic       branch;
  logic       selMuxPC2;
  logic       retire;
  logic       illegal;
  logic [2:0] state;
  modport slave (
    input  op, imem_ready, dmem_ready,
    output pc_we, ir_we, enW_Bank, enW_Mem, enR_Mem, selMuxMem_ALU, selMuxAddr,
           selMuxSign_Bank, selControl, branch, selMuxPC2, retire, illegal, state
  );
  modport master (
    output op, imem_ready, dmem_ready,
    input  pc_we, ir_we, enW_Bank, enW_Mem, enR_Mem, selMuxMem_ALU, selMuxAddr,
           selMuxSign_Bank, selControl, branch, selMuxPC2, retire, illegal, state
  );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle MIPS control FSM with memory wait handshakes and illegal-opcode halt
module control_multiciclo (
  input logic                  clk,
  input logic                  rst,
  control_multiciclo_if.slave  bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       legal, pc_we, ir_we, bank_n, wmem, rmem, branch, pc2;
  logic       sel_active, mem_alu, addr_rd, sign_imm;
  logic [3:0] ctl;
  always_comb begin
    legal = bus.op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    bank_n    = 1'b1;
    wmem      = 1'b0;
    rmem      = 1'b0;
    branch    = 1'b0;
    pc2       = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we   = bus.imem_ready;
        state_d = bus.imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        op_d      = bus.op;
        illegal_d = ~legal;
        pc_we     = legal && bus.op == 6'd2;
        pc2       = legal && bus.op == 6'd2;
        state_d   = !legal ? HALT : bus.op == 6'd2 ? FETCH : EXEC;
      end
      EXEC: begin
        branch  = op_q == 6'd4;
        pc_we   = op_q == 6'd4;
        state_d = op_q == 6'd4 ? FETCH : (op_q == 6'd35 || op_q == 6'd43) ? MEM : WB;
      end
      MEM: begin
        rmem    = op_q == 6'd35;
        wmem    = op_q != 6'd35;
        pc_we   = bus.dmem_ready && op_q != 6'd35;
        state_d = !bus.dmem_ready ? MEM : op_q == 6'd35 ? WB : FETCH;
      end
      WB: begin
        bank_n  = 1'b0;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  // selects follow op_q only while an instruction owns the ALU
  always_comb begin
    sel_active = state_q == EXEC || state_q == MEM || state_q == WB;
    ctl      = 4'd0;
    mem_alu  = 1'b1;
    addr_rd  = 1'b0;
    sign_imm = 1'b0;
    if (sel_active) begin
      case (op_q)
        6'd0:  begin ctl = 4'd8; addr_rd = 1'b1; end
        6'd4:  ctl = 4'd1;
        6'd8:  sign_imm = 1'b1;
        6'd9:  begin ctl = 4'd1; sign_imm = 1'b1; end
        6'd10: begin ctl = 4'd5; sign_imm = 1'b1; end
        6'd12: begin ctl = 4'd2; sign_imm = 1'b1; end
        6'd13: begin ctl = 4'd3; sign_imm = 1'b1; end
        6'd14: begin ctl = 4'd4; sign_imm = 1'b1; end
        6'd35: begin mem_alu = 1'b0; sign_imm = 1'b1; end
        6'd43: sign_imm = 1'b1;
        default: ctl = 4'd15;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end
  // reset masks strobes so the edge that resets cannot also commit a write
  assign bus.pc_we           = pc_we & ~rst;
  assign bus.retire          = pc_we & ~rst;
  assign bus.ir_we           = ir_we & ~rst;
  assign bus.enW_Bank        = bank_n | rst;
  assign bus.enW_Mem         = wmem & ~rst;
  assign bus.enR_Mem         = rmem & ~rst;
  assign bus.branch          = branch & ~rst;
  assign bus.selMuxPC2       = pc2 & ~rst;
  assign bus.selControl      = ctl;
  assign bus.selMuxMem_ALU   = mem_alu;
  assign bus.selMuxAddr      = addr_rd;
  assign bus.selMuxSign_Bank = sign_imm;
  assign bus.illegal         = illegal_q;
  assign bus.state           = state_q;
endmodule
